weighted_bitsum_pipe: RTL and testbench
=======================================

Name: weighted_bitsum_pipe

Overview:
- Parametrised, pipelined successor to the combinational bitsum tree.
- Each accepted N-bit mask word produces the sum of the programmable per-bit weights of its set bits, plus a threshold compare flag.
- Sits between the window/mask stage and the rank-select logic of the weighted order-statistics filter.
- Registered adder-tree levels and a valid/ready handshake with stall; weights are held in an internal register file.

Parameters:
- N, 9, number of mask bits (inputs to the tree); N >= 1.
- WW, 4, weight width in bits; each weight ranges 0..2^WW-1.
- SW, $clog2(N*(2**WW-1)+1), sum width (derived; 8 for the defaults); do not override.
- L, 1+$clog2(N), pipeline latency in cycles (derived; 5 for the defaults).

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  input word present.
- in_ready  out  1  block accepts a word this cycle.
- in_bits  in  N  mask word; bit i selects weight i.
- in_thr  in  SW  threshold, carried alongside the word.
- out_valid  out  1  result present.
- out_ready  in  1  downstream accepts the result.
- out_sum  out  SW  weighted sum.
- out_ge  out  1  out_sum >= the threshold of the same word.
- w_we  in  1  weight write strobe.
- w_addr  in  $clog2(N) (min 1)  weight index.
- w_data  in  WW  weight value.

Behaviour:
- Reset (async assert, sync-safe deassert): all pipeline valid bits 0; out_valid=0, out_sum=0, out_ge=0; every weight register = 1, so the default result equals plain popcount.
- Advance: adv = !out_valid || out_ready. in_ready = adv, which is purely combinational from out_valid and out_ready. When adv=0, every stage holds, including its valid bit.
- Accept occurs when in_valid && in_ready.
- Stage 0 registers the masked weights (in_bits[i] ? w[i] : 0), the word's in_thr, and valid.
- Stages 1..$clog2(N) each pairwise-add the previous level. An odd element passes through unchanged. Every level is registered; widths are zero-extended so no intermediate overflows.
- Final stage drives out_sum. out_ge is computed combinationally from the final-stage registers, or registered in the last stage; either way it aligns with out_sum.
- Latency: the result of a word accepted at cycle t appears with out_valid=1 at cycle t+L when there is no stall. Each stall cycle adds one cycle.
- Throughput: 1 word/cycle while out_ready=1.
- Bubbles are not collapsed. A stall freezes the whole pipe, including empty stages.
- Weight writes:
  - On w_we the weight at w_addr is updated at the clock edge.
  - A word accepted in the same cycle as a write uses the old weight.
  - The first word accepted in a later cycle uses the new weight.
  - Words already in flight are unaffected.
  - Writes with w_addr >= N are ignored.
  - Writes are accepted regardless of the stall state.
- When out_valid=0, out_sum and out_ge hold their last values; the bench must not check them then.
- N=1 case: no adder levels, L=1, out_sum is the zero-extended stage-0 register.
- Boundaries:
  - All bits set with all weights at max gives out_sum = N*(2^WW-1) (135 for the defaults), with no wrap.
  - in_thr=0 gives out_ge=1.
  - in_thr greater than the maximum sum gives out_ge=0.
- Reset mid-operation: all in-flight words are discarded, out_valid drops immediately (asynchronously), and weights return to 1.

Test Plan:
- Reset, default weights, out_ready=1.
  - Apply 000000000, 000000100, 111111111, 101010101, 100000000 on consecutive cycles.
  - Expect out_sum 0, 1, 9, 5, 1 on cycles t+5..t+9, with out_valid high exactly those 5 cycles.
- Write weights w[i]=i+1 (1..9).
  - Apply 111111111 with thr=45, then 101010101 with thr=26.
  - Expect out_sum=45 with out_ge=1, then out_sum=25 (1+3+5+7+9) with out_ge=0.
- Write all weights to 15 and apply 111111111 with thr=135, then thr=136.
  - Expect out_sum=135 both times; out_ge=1 then 0.
- Backpressure.
  - Stream 8 words while out_ready toggles 1,0,0,1,0,1,1,...
  - Expect in_ready==out_ready whenever out_valid=1, no word lost or duplicated, and in-order results matching a reference model.
- Weight update ordering.
  - In the same cycle, accept 000000001 and write w[0]=7.
  - Accept 000000001 again the next cycle.
  - Expect out_sum 1 then 7.
- Assert rst_n low mid-stream with 3 words in flight.
  - Expect out_valid=0 immediately, no stale results after release, and out_sum=popcount for the next word (weights back to 1).

Source files
------------

// File: rtl/weighted_bitsum_pipe.sv
// weighted_bitsum_pipe: pipelined weighted popcount of a mask word with threshold compare
module weighted_bitsum_pipe #(
   parameter int N = 9,
   parameter int WW = 4,
   parameter int SW = $clog2(N*(2**WW-1)+1),
   parameter int L = 1+$clog2(N),
   localparam int AW = N > 1 ? $clog2(N) : 1
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          in_valid,
   output logic          in_ready,
   input  logic [N-1:0]  in_bits,
   input  logic [SW-1:0] in_thr,
   output logic          out_valid,
   input  logic          out_ready,
   output logic [SW-1:0] out_sum,
   output logic          out_ge,
   input  logic          w_we,
   input  logic [AW-1:0] w_addr,
   input  logic [WW-1:0] w_data
);
   localparam int D = L - 1;
   logic          adv;
   logic [D:0]    vld;
   logic [SW-1:0] thr [D+1];
   logic [WW-1:0] w [N];
   assign adv = !vld[D] || out_ready;
   assign in_ready = adv;
   assign out_valid = vld[D];
   // valid bits shift on every advance; thresholds follow only real words so idle stages hold.
   // Thresholds reset to all-ones so out_ge reads 0 until the first result arrives.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         vld <= '0;
         for (int i = 0; i <= D; i++) thr[i] <= '1;
      end else if (adv) begin
         vld[0] <= in_valid;
         if (in_valid) thr[0] <= in_thr;
         for (int i = 1; i <= D; i++) begin
            vld[i] <= vld[i-1];
            if (vld[i-1]) thr[i] <= thr[i-1];
         end
      end
   end
   // weight register file; out-of-range addresses are dropped, writes ignore stalls
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < N; i++) w[i] <= WW'(1);
      end else if (w_we && 32'(w_addr) < N) begin
         w[w_addr] <= w_data;
      end
   end
   for (genvar k = 0; k <= D; k++) begin : g_lvl
      localparam int C = (N + (1 << k) - 1) >> k;
      logic [SW-1:0] v [C];
      if (k == 0) begin : g_in
         // stage 0: select each bit's weight, zero-extended to the sum width
         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) v <= '{default: '0};
            else if (adv && in_valid)
               for (int i = 0; i < N; i++) v[i] <= in_bits[i] ? SW'(w[i]) : '0;
         end
      end else begin : g_add
         localparam int P = (N + (1 << (k - 1)) - 1) >> (k - 1);
         logic [SW-1:0] nx [C];
         for (genvar j = 0; j < C; j++) begin : g_e
            if (2*j+1 < P) begin : g_p
               assign nx[j] = g_lvl[k-1].v[2*j] + g_lvl[k-1].v[2*j+1];
            end else begin : g_o
               assign nx[j] = g_lvl[k-1].v[2*j];
            end
         end
         // adder level: registers pairwise sums of the previous level when a word moves in
         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) v <= '{default: '0};
            else if (adv && vld[k-1]) v <= nx;
         end
      end
   end
   assign out_sum = g_lvl[D].v[0];
   assign out_ge = out_sum >= thr[D];
endmodule

// File: tb/tb_weighted_bitsum_pipe.sv
// tb_weighted_bitsum_pipe: randomized scoreboard bench for weighted_bitsum_pipe
module tb_weighted_bitsum_pipe;
   logic       clk = 0, rst_n = 0;
   logic       in_valid = 0, in_ready, out_valid, out_ready = 1, out_ge, w_we = 0;
   logic [8:0] in_bits = 0;
   logic [7:0] in_thr = 0, out_sum;
   logic [3:0] w_addr = 0, w_data = 0;
   int errs = 0, checks = 0, cyc = 0, vcount = 0;
   int wm [9];
   logic [8:0] exp_q [$];
   int acc_q [$], lat_q [$];
   logic acc;

   weighted_bitsum_pipe dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .in_bits(in_bits), .in_thr(in_thr), .out_valid(out_valid), .out_ready(out_ready),
      .out_sum(out_sum), .out_ge(out_ge), .w_we(w_we), .w_addr(w_addr), .w_data(w_data)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc++;

   task automatic chk(input string name, input int act, input int req);
      checks++;
      if (act != req) begin
         errs++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, req, cyc);
      end
   endtask

   // one driven cycle; the model computes the expected result from its own weight table
   task automatic step(input logic v, input logic [8:0] b, input logic [7:0] t, input logic r,
                       input logic we = 0, input logic [3:0] a = 0, input logic [3:0] d = 0);
      int s;
      @(negedge clk);
      in_valid = v; in_bits = b; in_thr = t; out_ready = r;
      w_we = we; w_addr = a; w_data = d;
      #1;
      acc = v && in_ready;
      if (acc) begin
         s = 0;
         for (int i = 0; i < 9; i++) if (b[i]) s += wm[i];
         exp_q.push_back({s[7:0], s >= int'(t)});
         acc_q.push_back(cyc);
      end
      if (we && a < 9) wm[a] = int'(d);
   endtask

   task automatic send(input logic [8:0] b, input logic [7:0] t, input logic r = 1);
      int n = 0;
      do begin
         step(1, b, t, r);
         n++;
      end while (!acc && n < 50);
      if (!acc) chk("accept_timeout", 0, 1);
   endtask

   task automatic wr(input logic [3:0] a, input logic [3:0] d);
      step(0, 0, 0, 1, 1, a, d);
   endtask

   task automatic drain();
      int n = 0;
      while (exp_q.size() != 0 && n < 200) begin
         step(0, 0, 0, 1);
         n++;
      end
      chk("drain_empty", exp_q.size(), 0);
      step(0, 0, 0, 1);
   endtask

   // monitor: compares every output transfer against the scoreboard head
   always begin
      logic [8:0] e;
      @(negedge clk);
      #2;
      if (rst_n && out_valid) begin
         vcount++;
         chk("in_ready_eq_out_ready", in_ready, out_ready);
         if (out_ready) begin
            if (exp_q.size() == 0) begin
               errs++; checks++;
               $display("FAIL unexpected_output: got sum=%0d with empty scoreboard", out_sum);
            end else begin
               e = exp_q.pop_front();
               chk("out_sum", out_sum, e[8:1]);
               chk("out_ge", out_ge, e[0]);
               lat_q.push_back(cyc - acc_q.pop_front());
            end
         end
      end
   end

   initial begin
      for (int i = 0; i < 9; i++) wm[i] = 1;
      repeat (2) @(posedge clk);
      #2;
      chk("rst_out_valid", out_valid, 0);
      chk("rst_out_sum", out_sum, 0);
      chk("rst_out_ge", out_ge, 0);
      chk("rst_in_ready", in_ready, 1);
      @(negedge clk); rst_n = 1;
      // popcount with default weights, latency and valid-cycle count
      vcount = 0; lat_q.delete();
      send(9'b000000000, 0); send(9'b000000100, 1); send(9'b111111111, 9);
      send(9'b101010101, 6); send(9'b100000000, 2);
      drain();
      repeat (4) step(0, 0, 0, 1);
      chk("valid_cycles", vcount, 5);
      chk("lat_count", lat_q.size(), 5);
      for (int i = 0; i < lat_q.size(); i++) chk("latency", lat_q[i], 5);
      // weights 1..9, with an out-of-range write that must be ignored
      for (int i = 0; i < 9; i++) wr(4'(i), 4'(i + 1));
      wr(4'd12, 4'd0);
      send(9'b111111111, 45); send(9'b101010101, 26);
      drain();
      // maximum weights and threshold boundaries
      for (int i = 0; i < 9; i++) wr(4'(i), 4'd15);
      send(9'b111111111, 135); send(9'b111111111, 136);
      send(9'b111111111, 255); send(9'b000000000, 0); send(9'b111111111, 0);
      drain();
      // backpressure with random words, fixed then random out_ready pattern
      begin
         logic pat [7] = '{1, 0, 0, 1, 0, 1, 1};
         for (int i = 0; i < 30; i++) begin
            logic r = i < 7 ? pat[i] : 1'($urandom_range(0, 1));
            if (i % 5 == 2) wr(4'($urandom_range(0, 8)), 4'($urandom));
            if (i < 8 || $urandom_range(0, 3) != 0) send(9'($urandom), 8'($urandom_range(0, 140)), r);
            else step(0, 0, 0, r);
         end
      end
      drain();
      // weight update ordering: same-cycle write uses old weight
      wr(0, 1);
      step(1, 9'b000000001, 1, 1, 1, 0, 7);
      chk("order_acc0", acc, 1);
      send(9'b000000001, 7);
      drain();
      // asynchronous reset mid-stream while stalled with words in flight
      for (int i = 0; i < 6; i++) send(9'($urandom), 8'($urandom));
      step(0, 0, 0, 0); step(0, 0, 0, 0);
      chk("pre_reset_valid", out_valid, 1);
      #1 rst_n = 0;
      #1;
      chk("async_rst_valid", out_valid, 0);
      chk("async_rst_sum", out_sum, 0);
      exp_q.delete(); acc_q.delete();
      for (int i = 0; i < 9; i++) wm[i] = 1;
      @(negedge clk); rst_n = 1;
      repeat (8) step(0, 0, 0, 1);
      send(9'b111111111, 9); send(9'b011010011, 6);
      drain();
      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: simulation exceeded time limit");
      $fatal(1);
   end
endmodule
